// File: rtl/serial_logic_seq_pkg.sv
// rtl/serial_logic_seq_pkg.sv - shared opcode and state encodings for the bit-serial logic sequencer
package serial_logic_seq_pkg;

  localparam logic [1:0] OP_XOR  = 2'd0;
  localparam logic [1:0] OP_OR   = 2'd1;
  localparam logic [1:0] OP_AND  = 2'd2;
  localparam logic [1:0] OP_NAND = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_logic_seq.sv
// rtl/serial_logic_seq.sv - feeds a 1-bit logic unit LSB first and assembles its WIDTH-bit result
module serial_logic_seq
  import serial_logic_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             lu_s0,
  output logic             lu_s1,
  output logic             lu_a,
  output logic             lu_b,
  input  logic             lu_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d    = op;
          a_d     = opa;
          b_d     = opb;
          res_d   = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // lu_out is only ever folded into res_reg; it never reaches an output directly
        res_d[cnt_q] = lu_out;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b0;
    lu_a      = 1'b0;
    lu_b      = 1'b0;
    lu_s0     = 1'b0;
    lu_s1     = 1'b0;
    case (state_q)
      ST_IDLE: in_ready = 1'b1;
      ST_RUN: begin
        busy  = 1'b1;
        lu_a  = a_q[cnt_q];
        lu_b  = b_q[cnt_q];
        lu_s0 = op_q[0];
        lu_s1 = op_q[1];
      end
      ST_DONE: begin
        busy      = 1'b1;
        res_valid = 1'b1;
      end
      default: in_ready = 1'b0;
    endcase
  end

  assign res = res_q;

endmodule

// File: tb/tb_serial_logic_seq.sv
// tb/tb_serial_logic_seq.sv - directed vector bench for serial_logic_seq with a behavioural logic unit
module tb_serial_logic_seq;
  import serial_logic_seq_pkg::*;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] opa, opb;
  logic             lu_s0, lu_s1, lu_a, lu_b, lu_out;
  logic             res_valid, res_ready;
  logic [WIDTH-1:0] res;
  logic             busy;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int acc_q[$];
  logic [WIDTH-1:0] got_q[$];

  typedef struct {
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] exp;
    bit               corrupt;
  } vec_t;

  serial_logic_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .opa(opa), .opb(opb),
    .lu_s0(lu_s0), .lu_s1(lu_s1), .lu_a(lu_a), .lu_b(lu_b), .lu_out(lu_out),
    .res_valid(res_valid), .res_ready(res_ready), .res(res), .busy(busy)
  );

  always #5 clk = ~clk;

  // the team's 1-bit logic unit sitting beside the sequencer
  always_comb begin
    lu_out = 1'b0;
    case ({lu_s1, lu_s0})
      OP_XOR:  lu_out = lu_a ^ lu_b;
      OP_OR:   lu_out = lu_a | lu_b;
      OP_AND:  lu_out = lu_a & lu_b;
      default: lu_out = ~(lu_a & lu_b);
    endcase
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset && in_valid && in_ready) acc_q.push_back(cyc);
    if (!reset && res_valid && res_ready) got_q.push_back(res);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_op(input vec_t v, input int hold_n);
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);
    op = v.op; opa = v.a; opb = v.b; in_valid = 1'b1;
    res_ready = (hold_n == 0);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      chk("run_lu_a", lu_a, v.a[i]);
      chk("run_lu_b", lu_b, v.b[i]);
      chk("run_lu_sel", {lu_s1, lu_s0}, v.op);
      chk("run_res_valid", res_valid, 0);
      chk("run_in_ready", in_ready, 0);
      chk("run_busy", busy, 1);
      if (v.corrupt) begin
        opa = WIDTH'($urandom); opb = WIDTH'($urandom); op = 2'($urandom);
      end
      @(negedge clk);
    end
    chk("done_res_valid", res_valid, 1);
    chk("done_res", res, v.exp);
    chk("done_lu_zero", {lu_a, lu_b, lu_s1, lu_s0}, 0);
    for (int h = 0; h < hold_n; h++) begin
      chk("hold_res_valid", res_valid, 1);
      chk("hold_res", res, v.exp);
      chk("hold_in_ready", in_ready, 0);
      in_valid = (h == 1);
      if (h == 1) opa = 8'h12;
      @(negedge clk);
    end
    in_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    chk("post_in_ready", in_ready, 1);
    chk("post_res_valid", res_valid, 0);
    chk("post_busy", busy, 0);
    chk("post_res", res, v.exp);
  endtask

  initial begin
    vec_t vecs[5];
    vecs[0] = '{OP_XOR,  8'hA5, 8'h3C, 8'h99, 1'b0};
    vecs[1] = '{OP_OR,   8'hA5, 8'h3C, 8'hBD, 1'b0};
    vecs[2] = '{OP_AND,  8'hA5, 8'h3C, 8'h24, 1'b0};
    vecs[3] = '{OP_NAND, 8'hA5, 8'h3C, 8'hDB, 1'b0};
    vecs[4] = '{OP_AND,  8'hF0, 8'h3C, 8'h30, 1'b1};

    reset = 1'b1; in_valid = 1'b0; op = '0; opa = '0; opb = '0; res_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res", res, 0);
    chk("rst_busy", busy, 0);
    chk("rst_lu", {lu_a, lu_b, lu_s1, lu_s0}, 0);

    for (int k = 0; k < 5; k++) do_op(vecs[k], 0);

    // result held while the consumer stalls; a stray in_valid must be ignored
    begin
      vec_t hv;
      hv = '{OP_XOR, 8'hFF, 8'h0F, 8'hF0, 1'b0};
      do_op(hv, 5);
      repeat (2) @(negedge clk);
      chk("stall_no_restart", busy, 0);
      chk("stall_res_kept", res, 8'hF0);
    end

    // reset on the third RUN cycle aborts the operation
    @(negedge clk);
    op = OP_AND; opa = 8'hFF; opb = 8'hFF; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_busy_before", busy, 1);
    got_q.delete();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_res", res, 0);
    chk("abort_busy", busy, 0);
    chk("abort_res_valid", res_valid, 0);
    for (int i = 0; i < 12; i++) begin
      if (res_valid) chk("abort_valid_rose", res_valid, 0);
      @(negedge clk);
    end
    chk("abort_no_result", got_q.size(), 0);

    // back-to-back with in_valid held high
    acc_q.delete(); got_q.delete();
    op = OP_XOR; opa = 8'h01; opb = 8'h01; in_valid = 1'b1;
    @(negedge clk);
    op = OP_OR; opa = 8'h80; opb = 8'h01;
    for (int i = 0; i < 40 && got_q.size() < 2; i++) begin
      if (acc_q.size() >= 2) in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("b2b_accepts", acc_q.size(), 2);
    chk("b2b_results", got_q.size(), 2);
    if (acc_q.size() >= 2) chk("b2b_spacing", acc_q[1] - acc_q[0], WIDTH + 2);
    if (got_q.size() >= 1) chk("b2b_res0", got_q[0], 8'h00);
    if (got_q.size() >= 2) chk("b2b_res1", got_q[1], 8'h81);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_logic_seq.md
Name: serial_logic_seq

Overview:
- Bit-serial sequencer for the team's 1-bit, 4-operation logic unit (xor/or/and/nand, selected by S1,S0).
- Accepts two WIDTH-bit operands and a 2-bit opcode over a valid/ready handshake.
- Drives the logic unit one bit per cycle, LSB first, and collects its 1-bit output into a WIDTH-bit result.
- Presents the result over a second valid/ready handshake. It sits both upstream (feeds a, b, S0, S1) and downstream (consumes out) of the logic unit.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operand word and opcode are present.
- in_ready  out  1  sequencer can accept an operation.
- op  in  2  opcode: 0 = xor, 1 = or, 2 = and, 3 = nand.
- opa  in  WIDTH  operand A.
- opb  in  WIDTH  operand B.
- lu_s0  out  1  logic-unit select bit 0 (= op_reg[0]).
- lu_s1  out  1  logic-unit select bit 1 (= op_reg[1]).
- lu_a  out  1  current bit of A to logic unit.
- lu_b  out  1  current bit of B to logic unit.
- lu_out  in  1  logic-unit result bit; combinational from lu_* in the same cycle.
- res_valid  out  1  result word is valid.
- res_ready  in  1  consumer accepts the result.
- res  out  WIDTH  result word.
- busy  out  1  high in RUN or DONE.

Behaviour:
- States: IDLE, RUN, DONE.
- Registers: op_reg (2 bits), a_reg, b_reg, res_reg (WIDTH bits each), cnt (clog2(WIDTH) bits).
- Reset (synchronous, sampled on the clk edge): state = IDLE, cnt = 0, op_reg/a_reg/b_reg/res_reg = 0.
  - Outputs after the reset edge: in_ready = 1, res_valid = 0, res = 0, busy = 0, lu_* = 0.
- IDLE:
  - in_ready = 1; lu_a = lu_b = lu_s0 = lu_s1 = 0.
  - On an edge with in_valid = 1: latch op/opa/opb, set cnt = 0, clear res_reg, go to RUN.
- RUN:
  - in_ready = 0.
  - lu_a = a_reg[cnt], lu_b = b_reg[cnt], lu_s1/lu_s0 = op_reg.
  - Each edge: res_reg[cnt] <= lu_out, cnt <= cnt + 1.
  - On the edge where cnt == WIDTH-1: capture the final bit, set cnt = 0, go to DONE.
- DONE:
  - res_valid = 1; res = res_reg, held stable; lu_* = 0; in_ready = 0.
  - On an edge with res_ready = 1: go to IDLE.
- res output: always equals res_reg; it is defined as a result only while res_valid = 1.
- Latency: res_valid rises exactly WIDTH edges after the accepting edge (WIDTH = 8 -> 8 cycles).
- Throughput: one operation per WIDTH+2 cycles minimum; no IDLE bypass from DONE.
- in_valid while in_ready = 0: ignored; no latching, no error.
- Operand changes on opa/opb/op after acceptance: no effect (registered copies only).
- res_ready while res_valid = 0: ignored.
- Reset asserted mid-RUN or in DONE: operation aborted; res_valid never rises for it; IDLE on the next edge.
- cnt never exceeds WIDTH-1; no wrap-around beyond DONE.
- All outputs are registered or decoded from registered state only.
  - No combinational path from in_valid or res_ready to any output.
  - lu_out reaches only the D input of res_reg.

Decomposition:
- Shared package/header holds:
  - opcode constants OP_XOR = 2'd0, OP_OR = 2'd1, OP_AND = 2'd2, OP_NAND = 2'd3;
  - state encodings ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2.
- No sub-module required. The logic unit is instantiated beside this block at the next level up, not inside it.

Test Plan (WIDTH = 8, sequencer wired to the team's 1-bit logic unit, res_ready = 1 unless stated):
- op = 0, A = 8'hA5, B = 8'h3C, one-cycle in_valid -> res_valid exactly 8 cycles after accept, res = 8'h99, in_ready = 1 one cycle after the res_ready handshake.
- Ops 1/2/3 with the same operands -> res = 8'hBD, 8'h24, 8'hDB respectively.
  - lu_s1/lu_s0 match op throughout RUN.
  - lu_a/lu_b sequence LSB-first = A[0..7], B[0..7].
- op = 0, A = 8'hFF, B = 8'h0F, res_ready held 0 for 5 cycles after res_valid -> res holds 8'hF0, res_valid stays 1, in_ready stays 0.
  - A second in_valid pulse (A = 8'h12) in this window is ignored; the next result is still 8'hF0.
- Reset asserted on the 3rd RUN cycle of op = 2, A = 8'hFF, B = 8'hFF -> next cycle IDLE, res = 8'h00, res_valid never asserts, busy = 0.
- Back-to-back: in_valid held high with two queued ops (xor 8'h01^8'h01, then or 8'h80|8'h01).
  - Results 8'h00 then 8'h81, each accepted in order.
  - Exactly WIDTH+2 cycles between the two accept edges.
- Operand corruption: change opa/opb/op every cycle during RUN -> result reflects only the values latched at accept.
